new_pe_unit: RTL and testbench

Processing element for the row-stationary convolution array. It holds a 3-tap shift window of 8-bit input-feature-map pixels and one set of three 4-bit filter weights. Each enabled cycle it computes a 3-tap dot product, adds the incoming partial sum, and registers the result toward the next PE. Ifmap and filter values are forwarded to neighbouring PEs through registered pass-through outputs.

---
 rtl/new_pe_unit.sv | 52 +++++
 tb/tb_new_pe_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/new_pe_unit.sv
// rtl/new_pe_unit.sv - row-stationary PE: 3-tap ifmap window, 4-bit weights, psum accumulate
// Optional NEW_PE_UNIT_PSUM_SAT_EN: saturate Psum_out at 14'h3FFF instead of wrapping.
module new_pe_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  Ifmap_shift_in,
  input  logic [11:0] Filtr_in,
  input  logic [13:0] Psum_in,
  output logic [7:0]  Ifmap_shift_out,
  output logic [11:0] Filtr_out,
  output logic [13:0] Psum_out
);

  logic [7:0]  x0, x1, x2;
  logic [11:0] w;
  logic [11:0] p0, p1, p2;
  logic [13:0] psum_next;

  // Products use the post-shift window and the weights arriving this cycle.
  assign p0 = Filtr_in[3:0]  * Ifmap_shift_in;
  assign p1 = Filtr_in[7:4]  * x0;
  assign p2 = Filtr_in[11:8] * x1;

`ifdef NEW_PE_UNIT_PSUM_SAT_EN
  logic [14:0] sum_full;
  assign sum_full  = {3'b000, p0} + {3'b000, p1} + {3'b000, p2} + {1'b0, Psum_in};
  assign psum_next = (sum_full > 15'd16383) ? 14'h3FFF : sum_full[13:0];
`else
  assign psum_next = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + Psum_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x0       <= '0;
      x1       <= '0;
      x2       <= '0;
      w        <= '0;
      Psum_out <= '0;
    end else if (en) begin
      x0       <= Ifmap_shift_in;
      x1       <= x0;
      x2       <= x1;
      w        <= Filtr_in;
      Psum_out <= psum_next;
    end
  end

  assign Ifmap_shift_out = x2;
  assign Filtr_out       = w;

endmodule

// File: tb/tb_new_pe_unit.sv
// tb/tb_new_pe_unit.sv - directed self-checking bench for new_pe_unit
module tb_new_pe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  Ifmap_shift_in;
  logic [11:0] Filtr_in;
  logic [13:0] Psum_in;
  logic [7:0]  Ifmap_shift_out;
  logic [11:0] Filtr_out;
  logic [13:0] Psum_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  new_pe_unit dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .Ifmap_shift_in  (Ifmap_shift_in),
    .Filtr_in        (Filtr_in),
    .Psum_in         (Psum_in),
    .Ifmap_shift_out (Ifmap_shift_out),
    .Filtr_out       (Filtr_out),
    .Psum_out        (Psum_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle away from the edge.
  task automatic step(input logic r, input logic e, input logic [7:0] px,
                      input logic [11:0] f, input logic [13:0] p);
    rst = r; en = e; Ifmap_shift_in = px; Filtr_in = f; Psum_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'd0, 12'h000, 14'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; Ifmap_shift_in = '0; Filtr_in = '0; Psum_in = '0;

    // Reset with random inputs and en high
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 8'($urandom), 12'($urandom), 14'($urandom));
    check("rst_psum", 32'(Psum_out), 0);
    check("rst_filt", 32'(Filtr_out), 0);
    check("rst_ifmap", 32'(Ifmap_shift_out), 0);

    // Basic dot product
    step(1'b0, 1'b1, 8'd10, 12'h321, 14'd0);
    check("basic_p1", 32'(Psum_out), 10);
    check("basic_filt", 32'(Filtr_out), 32'h321);
    step(1'b0, 1'b1, 8'd20, 12'h321, 14'd0);
    check("basic_p2", 32'(Psum_out), 40);
    check("basic_ifmap_early", 32'(Ifmap_shift_out), 0);
    step(1'b0, 1'b1, 8'd30, 12'h321, 14'd0);
    check("basic_p3", 32'(Psum_out), 100);
    check("basic_ifmap", 32'(Ifmap_shift_out), 10);

    // Psum chaining
    do_reset();
    step(1'b0, 1'b1, 8'd10, 12'h321, 14'd1000);
    check("chain_p1", 32'(Psum_out), 1010);
    step(1'b0, 1'b1, 8'd20, 12'h321, 14'd1000);
    check("chain_p2", 32'(Psum_out), 1040);
    step(1'b0, 1'b1, 8'd30, 12'h321, 14'd1000);
    check("chain_p3", 32'(Psum_out), 1100);

    // Enable hold
    do_reset();
    step(1'b0, 1'b1, 8'd10, 12'h321, 14'd0);
    step(1'b0, 1'b1, 8'd20, 12'h321, 14'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'd99, 12'hABC, 14'd500);
      check("hold_psum", 32'(Psum_out), 40);
      check("hold_filt", 32'(Filtr_out), 32'h321);
      check("hold_ifmap", 32'(Ifmap_shift_out), 0);
    end
    step(1'b0, 1'b1, 8'd30, 12'h321, 14'd0);
    check("hold_resume_psum", 32'(Psum_out), 100);
    check("hold_resume_ifmap", 32'(Ifmap_shift_out), 10);

    // Overflow
    do_reset();
    step(1'b0, 1'b1, 8'd255, 12'hFFF, 14'd16383);
`ifdef NEW_PE_UNIT_PSUM_SAT_EN
    check("ovf_p1", 32'(Psum_out), 16383);
`else
    check("ovf_p1", 32'(Psum_out), 3824);
`endif
    step(1'b0, 1'b1, 8'd255, 12'hFFF, 14'd16383);
    step(1'b0, 1'b1, 8'd255, 12'hFFF, 14'd16383);
`ifdef NEW_PE_UNIT_PSUM_SAT_EN
    check("ovf_p3", 32'(Psum_out), 16383);
`else
    check("ovf_p3", 32'(Psum_out), 11474);
`endif

    // Reset mid-stream, reset wins over en
    do_reset();
    step(1'b0, 1'b1, 8'd10, 12'h321, 14'd0);
    step(1'b0, 1'b1, 8'd20, 12'h321, 14'd0);
    step(1'b0, 1'b1, 8'd30, 12'h321, 14'd0);
    step(1'b1, 1'b1, 8'd40, 12'h321, 14'd9);
    check("mid_rst_psum", 32'(Psum_out), 0);
    check("mid_rst_filt", 32'(Filtr_out), 0);
    check("mid_rst_ifmap", 32'(Ifmap_shift_out), 0);
    step(1'b0, 1'b1, 8'd50, 12'h321, 14'd7);
    check("mid_rst_p1", 32'(Psum_out), 57);
    step(1'b0, 1'b1, 8'd60, 12'h321, 14'd7);
    check("mid_rst_p2", 32'(Psum_out), 167);
    check("mid_rst_ifmap2", 32'(Ifmap_shift_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
